// File: rtl/wallace_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wallace_mul_pipe
// Purpose  : Pipelined WIDTH x WIDTH multiplier. Each transaction can be
//            unsigned or two's-complement. Partial products use Baugh-Wooley
//            sign handling and are reduced by a Wallace tree of carry-save
//            full-adder layers, then summed by a carry-propagate adder.
//            Valid/ready handshake on both sides, bubble-collapsing stalls.
// Ports    : clk, rst_n      - clock, synchronous active-low reset
//            in_valid/ready  - operand handshake (a, b, is_signed)
//            out_valid/ready - result handshake (z, 2*WIDTH bits)
//            acc_clr         - only with WALLACE_MUL_ACC_EN: restart the
//                              running sum at this transaction
// Options  : `define WALLACE_MUL_ACC_EN adds an output accumulator; z then
//            carries the running sum including the head product.
// Revision : 1.0 - initial pipelined, parametrised release
// ============================================================================
module wallace_mul_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
`ifdef WALLACE_MUL_ACC_EN
  input  logic                 acc_clr,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z
);

  localparam int PW    = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the signed correction term.
  localparam int NROWS = WIDTH + 1;
  localparam int RIW   = $clog2(NROWS);

  typedef logic [NROWS-1:0][PW-1:0] rows_t;
  typedef logic [1:0][PW-1:0]       pair_t;

  // Row count left after one layer of 3:2 compression.
  function automatic int rows_after(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int count_layers(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = rows_after(r);
      l++;
    end
    return l;
  endfunction

  function automatic int rows_at(input int n, input int layer);
    int r;
    r = n;
    for (int i = 0; i < layer; i++) r = rows_after(r);
    return r;
  endfunction

  localparam int LAYERS = count_layers(NROWS);
  // For STAGES=4 the tree is cut before this layer.
  localparam int MID    = LAYERS / 2;

  // Baugh-Wooley partial products. In signed mode the terms where exactly
  // one operand bit is an MSB are inverted, and 2^WIDTH + 2^(2*WIDTH-1)
  // is added to cancel the constants that inversion introduced.
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic sgn);
    rows_t          rows;
    logic [PW-1:0]  row;
    rows = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = '0;
      for (int j = 0; j < WIDTH; j++) begin
        row[i+j] = (x[j] & y[i]) ^ (sgn & ((i == WIDTH-1) != (j == WIDTH-1)));
      end
      rows[i] = row;
    end
    rows[WIDTH] = sgn ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;
    return rows;
  endfunction

  // One Wallace layer: every full group of three rows goes through a row of
  // full-adder cells (sum row + left-shifted carry row); leftover rows pass
  // through unchanged. Outputs are packed from row 0 upward, rest zeroed.
  function automatic rows_t csa_layer(input rows_t rows, input int n);
    rows_t          res;
    logic [RIW-1:0] k;
    logic [PW-1:0]  x;
    logic [PW-1:0]  y;
    logic [PW-1:0]  c;
    res = '0;
    k   = '0;
    for (int g = 0; g < NROWS / 3; g++) begin
      if (g < n / 3) begin
        x = rows[3*g];
        y = rows[3*g+1];
        c = rows[3*g+2];
        res[k]           = x ^ y ^ c;
        res[k + RIW'(1)] = ((x & y) | (x & c) | (y & c)) << 1;
        k = k + RIW'(2);
      end
    end
    for (int r = 0; r < NROWS; r++) begin
      if (r >= (n / 3) * 3 && r < n) begin
        res[k] = rows[r];
        k = k + RIW'(1);
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake: stage k takes new data when it is empty or its successor
  // can take its current content; the chain ends at out_ready.
  // ---------------------------------------------------------------------
  logic [STAGES-1:0] r_vld;
  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_load;

  always_comb begin
    w_rdy         = '0;
    w_vin         = '0;
    w_rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) w_rdy[k] = ~r_vld[k] | w_rdy[k+1];
    w_vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) w_vin[k] = r_vld[k-1];
  end

  assign w_load    = w_rdy[STAGES-1:0] & w_vin;
  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[STAGES-1];

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  rows_t          w_pp;
  rows_t          w_src;
  pair_t          w_pair;
  logic [PW-1:0]  w_prod;
  logic [PW-1:0]  r_prod;
  rows_t          w_lin  [LAYERS];
  rows_t          w_lout [LAYERS];

  assign w_pp   = gen_pp(a, b, is_signed);
  assign w_prod = w_pair[0] + w_pair[1];

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    if (l == 0) begin : g_first
      assign w_lin[l] = w_src;
    end else if (STAGES == 4 && l == MID) begin : g_cut
      assign w_lin[l] = g_st4.r_cut;
    end else begin : g_chain
      assign w_lin[l] = w_lout[l-1];
    end
    assign w_lout[l] = csa_layer(w_lin[l], rows_at(NROWS, l));
  end

  // Stage split: fewer stages merge steps from the front, four stages
  // split the reduction tree at MID.
  if (STAGES == 1) begin : g_st1
    assign w_src  = w_pp;
    assign w_pair = w_lout[LAYERS-1][1:0];
  end else if (STAGES == 2) begin : g_st2
    pair_t r_pair;
    always_ff @(posedge clk) begin
      if (w_load[0]) r_pair <= w_lout[LAYERS-1][1:0];
    end
    assign w_src  = w_pp;
    assign w_pair = r_pair;
  end else if (STAGES == 3) begin : g_st3
    rows_t r_pp;
    pair_t r_pair;
    always_ff @(posedge clk) begin
      if (w_load[0]) r_pp   <= w_pp;
      if (w_load[1]) r_pair <= w_lout[LAYERS-1][1:0];
    end
    assign w_src  = r_pp;
    assign w_pair = r_pair;
  end else begin : g_st4
    rows_t r_pp;
    rows_t r_cut;
    pair_t r_pair;
    always_ff @(posedge clk) begin
      if (w_load[0]) r_pp   <= w_pp;
      if (w_load[1]) r_cut  <= w_lout[MID-1];
      if (w_load[2]) r_pair <= w_lout[LAYERS-1][1:0];
    end
    assign w_src  = r_pp;
    assign w_pair = r_pair;
  end

  // Valid bits and the final product register. r_prod only loads when a
  // real transaction enters the last stage, so it holds while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_prod <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) r_vld[k] <= w_vin[k];
      end
      if (w_load[STAGES-1]) r_prod <= w_prod;
    end
  end

`ifdef WALLACE_MUL_ACC_EN
  logic [STAGES-1:0] r_clr;
  logic [STAGES-1:0] w_cin;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     w_acc_next;

  always_comb begin
    w_cin    = '0;
    w_cin[0] = acc_clr;
    for (int k = 1; k < STAGES; k++) w_cin[k] = r_clr[k-1];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (w_load[k]) r_clr[k] <= w_cin[k];
    end
  end

  assign w_acc_next = (r_clr[STAGES-1] ? '0 : r_acc) + r_prod;

  // Commit only on an actual output transfer so stalls never double-count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (out_valid && out_ready) begin
      r_acc <= w_acc_next;
    end
  end

  // While empty, r_acc equals the last sum presented (0 after reset).
  assign z = out_valid ? w_acc_next : r_acc;
`else
  assign z = r_prod;
`endif

endmodule
`default_nettype wire
